// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive buffer: register selects and the bit
// positions used in the 32-bit words returned to the core.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      SEL_DATA   = 2'd0,
      SEL_STATUS = 2'd1,
      SEL_PEEK   = 2'd2,
      SEL_CTRL   = 2'd3
   } reg_sel_e;

   localparam int EMPTY_BIT = 16;
   localparam int FULL_BIT  = 17;
   localparam int OVR_BIT   = 18;
   localparam int FERR_BIT  = 19;
   localparam int VALID_BIT = 31;

   function automatic logic [31:0] ctrl_word(input logic irq_en);
      return {31'b0, irq_en};
   endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Storage array for the receive FIFO: synchronous write port and a
// combinational read port addressed by the read pointer.
module uart_rx_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 9
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // NOTE: the array has no reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive buffer between the UART deserializer and the core register port.
// Optional level/overrun interrupt output enabled by defining UART_RX_IRQ_EN.
module uart_rx_buffer
   import uart_rx_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
`ifdef UART_RX_IRQ_EN
   ,
   parameter int IRQ_THRESH = 8
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] rx_data_i,
   input  logic              rx_valid_i,
   input  logic              rx_frame_err_i,
   input  logic [1:0]        reg_sel_i,
   input  logic              rd_en_i,
   input  logic              clr_i,
   output logic [31:0]       reg_data_o,
   output logic              rx_avail_o,
   output logic              overrun_o
`ifdef UART_RX_IRQ_EN
   ,
   output logic              irq_o
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_W + 1;
   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
`ifdef UART_RX_IRQ_EN
   localparam logic        IRQ_EN_C = 1'b1;
   localparam logic [AW:0] THRESH_C = (AW + 1)'(IRQ_THRESH);
`else
   localparam logic        IRQ_EN_C = 1'b0;
`endif

   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_avail;
   logic          r_ovr;
   logic          r_ferr;
   logic [31:0]   r_reg_data;

   logic [EW-1:0] w_entry;
   logic          w_empty;
   logic          w_full;
   logic          w_pop_ok;
   logic          w_push_ok;
   logic          w_ovr_set;
   logic          w_ferr_set;
   logic          w_sticky_clr;
   logic [AW:0]   w_count_next;
   logic          w_ovr_next;
   logic          w_ferr_next;
   logic [31:0]   w_data_word;
   logic [31:0]   w_status_word;
   logic [31:0]   w_rd_word;

   uart_rx_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push_ok),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata ({rx_frame_err_i, rx_data_i}),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (w_entry)
   );

   // Extra pointer MSB differs only when the writer has lapped the reader.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // A pop frees a slot in the same cycle, so a push against a full FIFO still lands.
   assign w_pop_ok     = rd_en_i && (reg_sel_i == SEL_DATA) && !w_empty && !clr_i;
   assign w_push_ok    = rx_valid_i && !clr_i && (!w_full || w_pop_ok);
   assign w_ovr_set    = rx_valid_i && !clr_i && w_full && !w_pop_ok;
   assign w_ferr_set   = rx_valid_i && !clr_i && rx_frame_err_i;
   assign w_sticky_clr = rd_en_i && (reg_sel_i == SEL_STATUS);

   assign w_count_next = clr_i ? '0
                       : r_count + (w_push_ok ? ONE : '0) - (w_pop_ok ? ONE : '0);
   assign w_ovr_next   = !clr_i && (w_ovr_set  || (r_ovr  && !w_sticky_clr));
   assign w_ferr_next  = !clr_i && (w_ferr_set || (r_ferr && !w_sticky_clr));

   // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
   always_comb begin
      w_data_word = '0;
      if (!w_empty) begin
         w_data_word[VALID_BIT] = 1'b1;
         w_data_word[EW-1:0]    = w_entry;
      end

      w_status_word           = '0;
      w_status_word[AW:0]     = r_count;
      w_status_word[EMPTY_BIT] = w_empty;
      w_status_word[FULL_BIT]  = w_full;
      w_status_word[OVR_BIT]   = r_ovr;
      w_status_word[FERR_BIT]  = r_ferr;

      w_rd_word = ctrl_word(IRQ_EN_C);
      case (reg_sel_i)
         SEL_DATA,
         SEL_PEEK:   w_rd_word = w_data_word;
         SEL_STATUS: w_rd_word = w_status_word;
         default:    w_rd_word = ctrl_word(IRQ_EN_C);
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_avail    <= 1'b0;
         r_ovr      <= 1'b0;
         r_ferr     <= 1'b0;
         r_reg_data <= '0;
      end else begin
         if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + ONE;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ONE;
         end
         r_count <= w_count_next;
         r_avail <= (w_count_next != '0);
         r_ovr   <= w_ovr_next;
         r_ferr  <= w_ferr_next;
         if (rd_en_i && !clr_i) begin
            r_reg_data <= w_rd_word;
         end
      end
   end

`ifdef UART_RX_IRQ_EN
   logic r_irq;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= (w_count_next >= THRESH_C) || w_ovr_next;
      end
   end

   assign irq_o = r_irq;
`endif

   assign reg_data_o = r_reg_data;
   assign rx_avail_o = r_avail;
   assign overrun_o  = r_ovr;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer (DEPTH=16, DATA_W=8): table of
// single-cycle vectors plus hand-written overrun, full/empty and reset sequences.
module tb_uart_rx_buffer;
   import uart_rx_pkg::*;

`ifdef UART_RX_IRQ_EN
   localparam logic [31:0] CTRL_EXP = 32'h0000_0001;
`else
   localparam logic [31:0] CTRL_EXP = 32'h0000_0000;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic        rx_frame_err_i;
   logic [1:0]  reg_sel_i;
   logic        rd_en_i;
   logic        clr_i;
   logic [31:0] reg_data_o;
   logic        rx_avail_o;
   logic        overrun_o;
`ifdef UART_RX_IRQ_EN
   logic        irq_o;
`endif

   uart_rx_buffer dut (
      .clk            (clk),
      .reset          (reset),
      .rx_data_i      (rx_data_i),
      .rx_valid_i     (rx_valid_i),
      .rx_frame_err_i (rx_frame_err_i),
      .reg_sel_i      (reg_sel_i),
      .rd_en_i        (rd_en_i),
      .clr_i          (clr_i),
      .reg_data_o     (reg_data_o),
      .rx_avail_o     (rx_avail_o),
      .overrun_o      (overrun_o)
`ifdef UART_RX_IRQ_EN
      ,
      .irq_o          (irq_o)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] exp_q [$];

   typedef struct {
      logic        valid;
      logic [7:0]  data;
      logic        ferr;
      logic        rd;
      logic [1:0]  sel;
      logic        clr;
      logic [31:0] exp;
      logic        avail;
      string       name;
   } vec_t;

   vec_t vecs [$];

   function automatic vec_t mk(input logic valid, input logic [7:0] data, input logic ferr,
                               input logic rd, input logic [1:0] sel, input logic clr,
                               input logic [31:0] exp, input logic avail, input string name);
      vec_t v;
      v.valid = valid; v.data = data; v.ferr = ferr; v.rd = rd; v.sel = sel;
      v.clr = clr; v.exp = exp; v.avail = avail; v.name = name;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rx_valid_i     = 1'b0;
      rx_data_i      = '0;
      rx_frame_err_i = 1'b0;
      rd_en_i        = 1'b0;
      reg_sel_i      = SEL_DATA;
      clr_i          = 1'b0;
   endtask

   task automatic push(input logic [7:0] data, input logic ferr);
      rx_valid_i     = 1'b1;
      rx_data_i      = data;
      rx_frame_err_i = ferr;
      step();
      idle();
   endtask

   task automatic read(input logic [1:0] sel, input logic [31:0] exp, input string name);
      reg_sel_i = sel;
      rd_en_i   = 1'b1;
      exp_q.push_back(exp);
      step();
      idle();
      check(name, reg_data_o, exp_q.pop_front());
   endtask

   task automatic pulse_clr();
      clr_i = 1'b1;
      step();
      idle();
   endtask

   initial begin
      idle();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_reg_data", reg_data_o, 32'h0);
      check("rst_avail", {31'b0, rx_avail_o}, 32'h0);
      check("rst_overrun", {31'b0, overrun_o}, 32'h0);
      reset = 1'b1;
      step();

      // ---------------- table-driven single-cycle vectors ----------------
      vecs.push_back(mk(0, 8'h00, 0, 1, SEL_STATUS, 0, 32'h0001_0000, 0, "rst_status"));
      vecs.push_back(mk(1, 8'h41, 0, 0, SEL_DATA,   0, 32'h0,         1, "push41"));
      vecs.push_back(mk(1, 8'h42, 0, 0, SEL_DATA,   0, 32'h0,         1, "push42"));
      vecs.push_back(mk(0, 8'h00, 0, 1, SEL_STATUS, 0, 32'h0000_0002, 1, "status_cnt2"));
      vecs.push_back(mk(0, 8'h00, 0, 1, SEL_DATA,   0, 32'h8000_0041, 1, "pop41"));
      vecs.push_back(mk(0, 8'h00, 0, 1, SEL_DATA,   0, 32'h8000_0042, 0, "pop42"));
      vecs.push_back(mk(0, 8'h00, 0, 1, SEL_DATA,   0, 32'h0000_0000, 0, "pop_empty"));
      vecs.push_back(mk(1, 8'h7E, 1, 0, SEL_DATA,   0, 32'h0,         1, "push7e_ferr"));
      vecs.push_back(mk(0, 8'h00, 0, 1, SEL_PEEK,   0, 32'h8000_017E, 1, "peek7e"));
      vecs.push_back(mk(0, 8'h00, 0, 1, SEL_PEEK,   0, 32'h8000_017E, 1, "peek7e_again"));
      vecs.push_back(mk(0, 8'h00, 0, 1, SEL_STATUS, 0, 32'h0008_0001, 1, "status_ferr"));
      vecs.push_back(mk(0, 8'h00, 0, 1, SEL_STATUS, 0, 32'h0000_0001, 1, "status_ferr_cleared"));
      vecs.push_back(mk(0, 8'h00, 0, 1, SEL_CTRL,   0, CTRL_EXP,      1, "ctrl"));
      vecs.push_back(mk(0, 8'h00, 0, 0, SEL_DATA,   1, 32'h0,         0, "clr"));
      vecs.push_back(mk(0, 8'h00, 0, 1, SEL_STATUS, 0, 32'h0001_0000, 0, "status_after_clr"));
      vecs.push_back(mk(1, 8'h99, 1, 0, SEL_DATA,   1, 32'h0,         0, "clr_vs_push"));
      vecs.push_back(mk(0, 8'h00, 0, 1, SEL_STATUS, 0, 32'h0001_0000, 0, "status_clr_push"));

      foreach (vecs[i]) begin
         rx_valid_i     = vecs[i].valid;
         rx_data_i      = vecs[i].data;
         rx_frame_err_i = vecs[i].ferr;
         rd_en_i        = vecs[i].rd;
         reg_sel_i      = vecs[i].sel;
         clr_i          = vecs[i].clr;
         if (vecs[i].rd) exp_q.push_back(vecs[i].exp);
         step();
         idle();
         if (vecs[i].rd) check(vecs[i].name, reg_data_o, exp_q.pop_front());
         check({vecs[i].name, "_avail"}, {31'b0, rx_avail_o}, {31'b0, vecs[i].avail});
      end

      // ---------------- overrun: 17 pushes into 16 entries ----------------
      for (int i = 0; i < 17; i++) push(8'(i), 1'b0);
      check("ovr_flag", {31'b0, overrun_o}, 32'h1);
      read(SEL_PEEK, 32'h8000_0000, "ovr_peek_oldest");
      for (int i = 0; i < 16; i++) read(SEL_DATA, 32'h8000_0000 | i, $sformatf("ovr_drain_%0d", i));
      read(SEL_STATUS, 32'h0005_0000, "ovr_status_sticky");
      check("ovr_cleared", {31'b0, overrun_o}, 32'h0);
      read(SEL_STATUS, 32'h0001_0000, "ovr_status_clear");

      // ---------------- push + pop on a full FIFO ----------------
      for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i), 1'b0);
      rx_valid_i = 1'b1;
      rx_data_i  = 8'h55;
      rd_en_i    = 1'b1;
      reg_sel_i  = SEL_DATA;
      exp_q.push_back(32'h8000_00A0);
      step();
      idle();
      check("full_pushpop_data", reg_data_o, exp_q.pop_front());
      check("full_pushpop_ovr", {31'b0, overrun_o}, 32'h0);
      read(SEL_STATUS, 32'h0002_0010, "full_pushpop_status");
      for (int i = 1; i < 16; i++) read(SEL_DATA, 32'h8000_00A0 + i, $sformatf("full_drain_%0d", i));
      read(SEL_DATA, 32'h8000_0055, "full_drain_55");
      read(SEL_DATA, 32'h0, "full_drain_empty");

      // ---------------- push + pop on an empty FIFO: no bypass ----------------
      rx_valid_i = 1'b1;
      rx_data_i  = 8'h66;
      rd_en_i    = 1'b1;
      reg_sel_i  = SEL_DATA;
      exp_q.push_back(32'h0);
      step();
      idle();
      check("empty_pushpop_data", reg_data_o, exp_q.pop_front());
      read(SEL_STATUS, 32'h0000_0001, "empty_pushpop_status");
      read(SEL_DATA, 32'h8000_0066, "empty_pushpop_stored");

      // ---------------- STATUS clear-on-read vs same-cycle set ----------------
      push(8'h01, 1'b1);
      rx_valid_i     = 1'b1;
      rx_data_i      = 8'h02;
      rx_frame_err_i = 1'b1;
      rd_en_i        = 1'b1;
      reg_sel_i      = SEL_STATUS;
      exp_q.push_back(32'h0008_0001);
      step();
      idle();
      check("setwins_status", reg_data_o, exp_q.pop_front());
      read(SEL_STATUS, 32'h0008_0002, "setwins_resticky");
      read(SEL_STATUS, 32'h0000_0002, "setwins_cleared");
      pulse_clr();

`ifdef UART_RX_IRQ_EN
      // ---------------- interrupt threshold ----------------
      for (int i = 0; i < 7; i++) push(8'h20 + 8'(i), 1'b0);
      check("irq_below", {31'b0, irq_o}, 32'h0);
      push(8'h27, 1'b0);
      check("irq_at_thresh", {31'b0, irq_o}, 32'h1);
      read(SEL_DATA, 32'h8000_0020, "irq_pop");
      check("irq_after_pop", {31'b0, irq_o}, 32'h0);
      pulse_clr();
`endif

      // ---------------- asynchronous reset mid-stream ----------------
      for (int i = 0; i < 17; i++) push(8'h30 + 8'(i), 1'b0);
      read(SEL_PEEK, 32'h8000_0030, "prerst_peek");
      check("prerst_ovr", {31'b0, overrun_o}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_data", reg_data_o, 32'h0);
      check("async_rst_avail", {31'b0, rx_avail_o}, 32'h0);
      check("async_rst_ovr", {31'b0, overrun_o}, 32'h0);
`ifdef UART_RX_IRQ_EN
      check("async_rst_irq", {31'b0, irq_o}, 32'h0);
`endif
      step();
      reset = 1'b1;
      step();
      read(SEL_STATUS, 32'h0001_0000, "postrst_status");
      read(SEL_DATA, 32'h0, "postrst_data");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- Receive-side buffer between the UART receive deserializer and the core's memory-mapped UART register port (GPIO_In path).
- Captures each received byte from a one-cycle valid strobe into a FIFO.
- Tracks sticky overrun and frame-error status.
- Presents data and status as 32-bit words selected by the core's 2-bit register select, with pop-on-read semantics.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of two, minimum 2.
- DATA_W, 8: received character width.
- IRQ_THRESH, 8: fill level that raises irq_o. Used only when UART_RX_IRQ_EN is defined.

Ports:
- clk  in  1  system clock (PLL output domain)
- reset  in  1  asynchronous, active-low reset
- rx_data_i  in  DATA_W  byte from deserializer; valid only while rx_valid_i=1
- rx_valid_i  in  1  one-cycle push strobe
- rx_frame_err_i  in  1  stop-bit error for the byte in rx_data_i; sampled with rx_valid_i
- reg_sel_i  in  2  register select from core: 0=DATA, 1=STATUS, 2=PEEK, 3=CTRL
- rd_en_i  in  1  one-cycle read strobe from core
- clr_i  in  1  one-cycle flush strobe
- reg_data_o  out  32  registered read data
- rx_avail_o  out  1  FIFO not empty (registered)
- overrun_o  out  1  sticky overrun flag
- irq_o  out  1  present only with UART_RX_IRQ_EN

Behaviour:
- Reset (reset=0, async) sets:
  - rd/wr pointers = 0, count = 0
  - reg_data_o = 0, rx_avail_o = 0
  - overrun and frame-error stickies = 0, irq_o = 0
- Reset mid-operation discards all FIFO contents immediately. Storage RAM contents need not be cleared.
- Entry format: {frame_err, data}, DATA_W+1 bits.
- Push: rx_valid_i=1 and not full writes the entry at wr_ptr; wr_ptr increments modulo DEPTH.
- Frame-error sticky is set on any push with rx_frame_err_i=1, whether or not the byte is stored.
- Push while full (with no pop that cycle):
  - byte dropped;
  - overrun sticky set;
  - pointers unchanged.
- Pop: rd_en_i=1, reg_sel_i=DATA, not empty → rd_ptr increments modulo DEPTH.
- Read latency: reg_data_o is updated one clock after the rd_en_i cycle and holds until the next rd_en_i.
  - DATA, non-empty: reg_data_o = {1'b1 valid@31, 22'b0, frame_err@8, data@[7:0]}.
  - DATA, empty: reg_data_o = 32'h0; no pointer change; no error flag.
  - PEEK: same format as DATA, but no pop.
  - STATUS: count@[4:0] (clog2(DEPTH)+1 bits, LSB-aligned), empty@16, full@17, overrun@18, frame_err_sticky@19, rest 0.
  - CTRL read: returns {31'b0, UART_RX_IRQ_EN compiled?1:0}.
- Simultaneous push and pop:
  - Full: both succeed; count unchanged; no overrun.
  - Empty: pop returns empty word (no bypass); push is stored; count becomes 1.
- Count arithmetic: count_next = count + push_ok - pop_ok. Never exceeds DEPTH, never negative.
- Pointer wrap uses an extra MSB to distinguish full from empty.
- clr_i flushes the FIFO (pointers and count = 0) and clears both stickies.
  - It has priority over a same-cycle push or pop; that push is dropped without setting overrun.
  - reg_data_o is unchanged.
- Sticky clear on read: STATUS read (rd_en_i with sel=STATUS) clears overrun and frame_err stickies in the cycle after the returned value is captured.
  - The returned word shows the pre-clear values.
  - A push error in that same cycle re-sets the sticky; set wins.
- rx_avail_o = registered !empty, updated the same edge as count.
- overrun_o = sticky overrun register.

Optional Feature:
- Macro UART_RX_IRQ_EN.
- Defined:
  - irq_o port exists.
  - irq_o is registered: (count_next >= IRQ_THRESH) | overrun_next.
  - Deasserts when the level drops below IRQ_THRESH and the overrun sticky is cleared.
- Not defined:
  - irq_o port absent.
  - IRQ_THRESH is unused.
  - CTRL bit0 reads 0.

Decomposition:
- Package uart_rx_pkg holds:
  - register select constants: SEL_DATA=2'd0, SEL_STATUS=2'd1, SEL_PEEK=2'd2, SEL_CTRL=2'd3;
  - STATUS bit positions (EMPTY_BIT=16, FULL_BIT=17, OVR_BIT=18, FERR_BIT=19);
  - DATA valid bit position 31.
- One sub-module, uart_rx_fifo_mem:
  - DEPTH x (DATA_W+1) storage;
  - synchronous write, combinational read at rd_ptr.
- Pointer, count, flag and read-mux logic stay in uart_rx_buffer.

Test Plan:
- Reset then STATUS read → reg_data_o = 0x0001_0000 (empty=1, count=0); rx_avail_o=0.
- Push 0x41, 0x42 → STATUS count=2. DATA read ×2 → 0x8000_0041 then 0x8000_0042. Third DATA read → 0x0000_0000.
- Push 17 bytes 0x00..0x10 with DEPTH=16 → STATUS = 0x0006_0010 (full, overrun, count=16). Drain returns 0x00..0x0F in order. Next STATUS read shows overrun, the following one does not.
- With FIFO full, push 0x55 and DATA-pop in the same cycle → pop returns the oldest byte, count stays 16, overrun stays 0, 0x55 is read last.
- Push 0x7E with rx_frame_err_i=1 → PEEK = 0x8000_017E, no pop. STATUS bit19=1. clr_i → STATUS = 0x0001_0000.
- With UART_RX_IRQ_EN and IRQ_THRESH=8:
  - 7 pushes → irq_o=0; 8th push → irq_o=1 one cycle later.
  - One pop → irq_o=0.
  - Assert reset mid-stream → irq_o, rx_avail_o, count = 0 immediately.
